mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Streams a program image into the pipelined MIPS32 core's memory over a valid/ready handshake, then releases the core to run and watches for HALT. It sits directly upstream of the processor. It replaces hand-poking `Mem[]` and `PC` from the bench with a synthesizable load path. It appends an `HLT` (32'hfc000000) when the image does not end in one, so the core can never run off the end of the loaded image.

## Interface
- ADDR_W, 10, memory word-address width; depth = 2^ADDR_W words
- HLT_WORD, 32'hfc000000, word appended as terminator (opcode 6'b111111)
- clk1  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a load from address 0 (honoured only in IDLE, DONE, ERR)
- in_valid  in  1  upstream word valid
- in_ready  out  1  loader can accept a word
- in_data  in  32  instruction word
- in_last  in  1  marks final word of image (qualified by in_valid)
- mem_we  out  1  memory write strobe, one cycle per word
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  write data
- cpu_run  out  1  high = core released (PC=0, pipeline cleared beforehand by core on rising edge)
- halted  in  1  core HALTED flag
- busy  out  1  high in LOAD, PAD, FLUSH, RUN
- done  out  1  program halted cleanly; sticky until next start
- err_overflow  out  1  image did not fit; sticky until next start
- word_count  out  ADDR_W+1  words written this load, including pad

## Operation
- States: IDLE, LOAD, PAD, FLUSH, RUN, DONE, ERR.
- IDLE: in_ready=0, cpu_run=0. start -> LOAD, ptr=0, word_count=0, done/err cleared.
- LOAD: in_ready=1. Transfer = in_valid && in_ready. On transfer, write in_data at ptr, ptr++, word_count++.
  - in_last and in_data[31:26]==6'b111111 -> FLUSH.
  - in_last and not HLT, ptr < 2^ADDR_W-1 -> PAD.
  - in_last and not HLT, ptr == 2^ADDR_W-1 -> ERR (no room for pad).
  - not in_last and ptr == 2^ADDR_W-1 -> ERR (word is still written).
- PAD: one cycle. Writes HLT_WORD at ptr, word_count++ -> FLUSH. in_ready=0.
- FLUSH: one idle cycle so the last write lands -> RUN.
- RUN: cpu_run=1. halted high -> DONE.
- DONE: done=1, cpu_run=0. start -> LOAD.
- ERR: err_overflow=1, cpu_run=0, in_ready=0. start -> LOAD.
- start in LOAD, PAD, FLUSH, or RUN is ignored.
- in_data and in_last are ignored when in_valid=0.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, done=0, err_overflow=0, word_count=0.
- mem_we, mem_addr, and mem_wdata are registered: a transfer in cycle n produces a write strobe in cycle n+1 for exactly one cycle.
- Back-to-back transfers give one write per cycle. Input gaps give no strobe.
- in_ready is registered from state. It drops the cycle after the in_last transfer. No word is accepted after in_last.
- Latency from the in_last transfer (HLT-terminated image) to cpu_run=1 is 2 cycles: FLUSH, then RUN.
- With a pad word, that latency is 3 cycles.
- halted is sampled each RUN cycle. done rises 1 cycle after halted is seen high.
- Reset asserted mid-LOAD or mid-RUN drops cpu_run and mem_we in the same instant. A partially loaded image is not resumed.

## Test plan
- Load the 9-word image 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (in_last on the 9th word):
  - 9 strobes at addresses 0..8 with no pad.
  - word_count=9.
  - cpu_run high 2 cycles after the last transfer.
  - Model raising halted -> done=1, cpu_run=0.
- 3-word image 2801000a, 28020014, 00222000, ending without HLT -> pad write fc000000 at addr 3, word_count=4, cpu_run 3 cycles after in_last.
- Random in_valid gaps on the 9-word image -> write order and data identical to the back-to-back case, with no strobe during gaps.
- ADDR_W=3, 8 words with no in_last:
  - All 8 written at addr 0..7.
  - err_overflow=1 and in_ready=0 after the 8th.
  - cpu_run never rises.
- ADDR_W=3, 8th word is in_last but not HLT -> ERR, err_overflow=1.
- Assert rst at the 4th transfer -> all outputs return to reset values asynchronously. A new start reloads from addr 0 with word_count restarting at 0.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Streams a program image into MIPS32 instruction memory over valid/ready, appends an HLT
// terminator if the image lacks one, then releases the core and waits for it to halt.
module mips32_prog_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] HLT_WORD = 32'hfc000000
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    input  logic              halted,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [5:0]        HLT_OP  = 6'b111111;
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_run_q, cpu_run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer_s;

    assign xfer_s = in_valid && in_ready_q;

    // Next-state, write-port and status decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = {ADDR_W{1'b0}};
                    count_d = {(ADDR_W+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (xfer_s) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                    // An HLT-terminated image fits even in the very last word.
                    if (in_last && (in_data[31:26] == HLT_OP)) begin
                        state_d = S_FLUSH;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d = S_ERR;
                    end else if (in_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_PAD: begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = HLT_WORD;
                count_d = count_q + CNT_ONE;
                state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_RUN;
            S_RUN: begin
                if (halted) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_LOAD);
        cpu_run_d  = (state_d == S_RUN);
        busy_d     = (state_d == S_LOAD) || (state_d == S_PAD) ||
                     (state_d == S_FLUSH) || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    // State and registered outputs; reset drops every output immediately.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W+1){1'b0}};
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= 32'h0000_0000;
            in_ready_q <= 1'b0;
            cpu_run_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            cpu_run_q  <= cpu_run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_run      = cpu_run_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench: a 1K-word loader for the load/pad/run/reset cases and an 8-word loader
// for overflow; sel chooses which instance the shared checks observe.
module tb_mips32_prog_loader;

    logic        clk1, rst, start_a, start_b, in_valid, in_last, halted, sel;
    logic [31:0] in_data;

    logic        in_ready_a, mem_we_a, cpu_run_a, busy_a, done_a, err_a;
    logic [9:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [10:0] wc_a;
    logic        in_ready_b, mem_we_b, cpu_run_b, busy_b, done_b, err_b;
    logic [2:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [3:0]  wc_b;

    logic        v_in_ready, v_mem_we, v_cpu_run, v_busy, v_done, v_err;
    logic [9:0]  v_mem_addr;
    logic [31:0] v_mem_wdata;
    logic [10:0] v_wc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [9:0]  cap_a [$];
    logic [31:0] cap_d [$];

    logic [31:0] prog9 [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                                 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                                 32'hfc000000};
    logic [31:0] prog3 [0:2] = '{32'h2801000a, 32'h28020014, 32'h00222000};
    logic [31:0] img   [0:8];

    mips32_prog_loader #(.ADDR_W(10)) dut (
        .clk1(clk1), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .cpu_run(cpu_run_a), .halted(halted), .busy(busy_a),
        .done(done_a), .err_overflow(err_a), .word_count(wc_a)
    );

    mips32_prog_loader #(.ADDR_W(3)) dut_small (
        .clk1(clk1), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .cpu_run(cpu_run_b), .halted(halted), .busy(busy_b),
        .done(done_b), .err_overflow(err_b), .word_count(wc_b)
    );

    assign v_in_ready  = sel ? in_ready_b : in_ready_a;
    assign v_mem_we    = sel ? mem_we_b : mem_we_a;
    assign v_mem_addr  = sel ? {7'd0, mem_addr_b} : mem_addr_a;
    assign v_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
    assign v_cpu_run   = sel ? cpu_run_b : cpu_run_a;
    assign v_busy      = sel ? busy_b : busy_a;
    assign v_done      = sel ? done_b : done_a;
    assign v_err       = sel ? err_b : err_a;
    assign v_wc        = sel ? {7'd0, wc_b} : wc_a;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Record every memory write strobe seen by the selected instance.
    always @(negedge clk1) begin
        if (v_mem_we) begin
            cap_a.push_back(v_mem_addr);
            cap_d.push_back(v_mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk1);
        cap_a.delete();
        cap_d.delete();
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk1);
        start_a = 1'b0;
        start_b = 1'b0;
        check_eq("start_ready", 32'(v_in_ready), 32'd1);
        check_eq("start_clears_done", 32'(v_done), 32'd0);
        check_eq("start_clears_err", 32'(v_err), 32'd0);
    endtask

    task automatic send_image(input int n, input bit gaps, input bit use_last);
        int   idx    = 0;
        int   budget = 0;
        logic xfer   = 1'b0;
        while (idx < n && budget < 100) begin
            @(negedge clk1);
            check_eq("we_follows_xfer", 32'(v_mem_we), 32'(xfer));
            if (gaps && ($urandom_range(2, 0) == 0)) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 32'hdeadbeef;
            end else begin
                in_valid = 1'b1;
                in_data  = img[idx];
                in_last  = use_last && (idx == n - 1);
            end
            xfer = in_valid && v_in_ready;
            @(posedge clk1);
            if (xfer) idx++;
            budget++;
        end
        if (idx < n) check_eq("load_budget", 32'(idx), 32'(n));
    endtask

    task automatic check_writes(input int n, input bit pad);
        check_eq("write_count", 32'(cap_a.size()), 32'(n + int'(pad)));
        for (int i = 0; i < n && i < cap_a.size(); i++) begin
            check_eq("write_addr", 32'(cap_a[i]), 32'(i));
            check_eq("write_data", cap_d[i], img[i]);
        end
        if (pad && cap_a.size() > n) begin
            check_eq("pad_addr", 32'(cap_a[n]), 32'(n));
            check_eq("pad_data", cap_d[n], 32'hfc000000);
        end
    endtask

    task automatic finish_load(input int n, input bit pad);
        @(negedge clk1);
        check_eq("ready_drop", 32'(v_in_ready), 32'd0);
        check_eq("run_lat_1", 32'(v_cpu_run), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk1);
        if (pad) begin
            check_eq("run_lat_2", 32'(v_cpu_run), 32'd0);
            @(negedge clk1);
        end
        check_eq("run_rise", 32'(v_cpu_run), 32'd1);
        check_eq("run_busy", 32'(v_busy), 32'd1);
        check_eq("word_count", 32'(v_wc), 32'(n + int'(pad)));
        check_writes(n, pad);
    endtask

    task automatic halt_core();
        repeat (3) begin
            @(negedge clk1);
            check_eq("run_hold", 32'(v_cpu_run), 32'd1);
            check_eq("run_not_done", 32'(v_done), 32'd0);
        end
        halted = 1'b1;
        @(negedge clk1);
        halted = 1'b0;
        check_eq("halt_done", 32'(v_done), 32'd1);
        check_eq("halt_run_off", 32'(v_cpu_run), 32'd0);
        check_eq("halt_busy_off", 32'(v_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; start_a = 1'b0; start_b = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0; halted = 1'b0;
        for (int i = 0; i < 9; i++) img[i] = prog9[i];

        repeat (3) @(negedge clk1);
        check_eq("rst_ready", 32'(v_in_ready), 32'd0);
        check_eq("rst_we", 32'(v_mem_we), 32'd0);
        check_eq("rst_addr", 32'(v_mem_addr), 32'd0);
        check_eq("rst_wdata", v_mem_wdata, 32'd0);
        check_eq("rst_run", 32'(v_cpu_run), 32'd0);
        check_eq("rst_busy", 32'(v_busy), 32'd0);
        check_eq("rst_done", 32'(v_done), 32'd0);
        check_eq("rst_err", 32'(v_err), 32'd0);
        check_eq("rst_wc", 32'(v_wc), 32'd0);
        rst = 1'b0;

        // 9-word HLT-terminated image, back to back
        pulse_start();
        send_image(9, 1'b0, 1'b1);
        finish_load(9, 1'b0);
        halt_core();

        // 3-word image without HLT gets a pad word
        for (int i = 0; i < 3; i++) img[i] = prog3[i];
        pulse_start();
        send_image(3, 1'b0, 1'b1);
        finish_load(3, 1'b1);
        halt_core();

        // 9-word image with random input gaps
        for (int i = 0; i < 9; i++) img[i] = prog9[i];
        pulse_start();
        send_image(9, 1'b1, 1'b1);
        finish_load(9, 1'b0);
        halt_core();

        // reset at the 4th transfer, then reload from address 0
        pulse_start();
        send_image(4, 1'b0, 1'b0);
        #1 check_eq("pre_rst_we", 32'(v_mem_we), 32'd1);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("arst_we", 32'(v_mem_we), 32'd0);
        check_eq("arst_ready", 32'(v_in_ready), 32'd0);
        check_eq("arst_addr", 32'(v_mem_addr), 32'd0);
        check_eq("arst_wdata", v_mem_wdata, 32'd0);
        check_eq("arst_wc", 32'(v_wc), 32'd0);
        check_eq("arst_busy", 32'(v_busy), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) img[i] = prog3[i];
        pulse_start();
        send_image(3, 1'b0, 1'b1);
        finish_load(3, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_run", 32'(v_cpu_run), 32'd0);
        check_eq("arst_run_busy", 32'(v_busy), 32'd0);
        @(negedge clk1);
        rst = 1'b0;

        // 8-word memory: 8 words without in_last overflow
        sel = 1'b1;
        for (int i = 0; i < 9; i++) img[i] = prog9[i];
        pulse_start();
        send_image(8, 1'b0, 1'b0);
        @(negedge clk1);
        in_valid = 1'b0;
        check_eq("ovf_we", 32'(v_mem_we), 32'd1);
        check_eq("ovf_addr", 32'(v_mem_addr), 32'd7);
        check_eq("ovf_err", 32'(v_err), 32'd1);
        check_eq("ovf_ready", 32'(v_in_ready), 32'd0);
        check_eq("ovf_wc", 32'(v_wc), 32'd8);
        repeat (4) begin
            @(negedge clk1);
            check_eq("ovf_no_run", 32'(v_cpu_run), 32'd0);
            check_eq("ovf_ready_low", 32'(v_in_ready), 32'd0);
        end
        check_writes(8, 1'b0);

        // 8-word memory: 8th word is in_last but not HLT, no room for the pad
        pulse_start();
        send_image(8, 1'b0, 1'b1);
        @(negedge clk1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("last_ovf_err", 32'(v_err), 32'd1);
        check_eq("last_ovf_run", 32'(v_cpu_run), 32'd0);
        @(negedge clk1);
        check_eq("last_ovf_wc", 32'(v_wc), 32'd8);
        check_eq("last_ovf_no_run", 32'(v_cpu_run), 32'd0);
        check_writes(8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
